seg_scan_driver: RTL

Time-multiplexed driver for the board's eight-digit common-anode 7-segment display. It sits directly downstream of the sequence-detector state register and any other status values. It accepts a 32-bit hex word and per-digit enable/decimal-point masks, then scans one digit at a time, so every digit can show its own nibble instead of hard-wiring a single anode on. Value updates are tear-free: a new word takes effect only at a frame boundary.

---
 rtl/seg_scan_driver_pkg.sv | 19 +
 rtl/seg_glyph_rom.sv | 11 +
 rtl/seg_scan_driver.sv | 89 ++++++++
 3 files changed

// File: rtl/seg_scan_driver_pkg.sv
// rtl/seg_scan_driver_pkg.sv - shared constants and glyph table for the 7-segment scan driver
package seg_scan_driver_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int NUM_GLYPHS = 16;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {a,b,c,d,e,f,g}, a in the MSB, hex digits 0-F
  localparam logic [6:0] GLYPH_TABLE [NUM_GLYPHS] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

endpackage

// File: rtl/seg_glyph_rom.sv
// rtl/seg_glyph_rom.sv - combinational nibble to active-low segment lookup
module seg_glyph_rom
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - eight-digit multiplexed 7-segment driver with frame-aligned value updates
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 4000,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        load,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_en,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);

  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_next;
  logic [2:0]    idx;
  phase_t        phase;
  logic [31:0]   hold;
  logic [31:0]   shadow;
  logic          pending;
  logic          tick;
  logic          wrap;
  logic [6:0]    glyph;

  assign tick = (pcnt == PW'(DIV - 1));
  assign wrap = tick && (idx == 3'd7);

  always_comb begin
    pcnt_next = pcnt + PW'(1);
    if (tick) begin
      pcnt_next = '0;
    end
  end

  seg_glyph_rom u_glyph (
    .nibble (shadow[{idx, 2'b00} +: 4]),
    .seg    (glyph)
  );

  // Outputs are computed from the current slot state, so they trail pcnt/idx
  // by one clock; seg and anode stay aligned to the same digit.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pcnt       <= '0;
      idx        <= '0;
      phase      <= PH_BLANK;
      hold       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      anode      <= 8'hFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      pcnt  <= pcnt_next;
      phase <= (pcnt_next < PW'(BLANK_CYC)) ? PH_BLANK : PH_SHOW;
      if (tick) begin
        idx <= idx + 3'd1;
      end

      // A load landing on the frame tick stays pending for the next frame.
      if (wrap && pending) begin
        shadow <= hold;
      end
      if (load) begin
        hold    <= value;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end

      anode      <= (phase == PH_SHOW && digit_en[idx]) ? ~(8'd1 << idx) : 8'hFF;
      seg        <= glyph;
      dp         <= ~dp_en[idx];
      frame_done <= wrap;
    end
  end

endmodule
